// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 16x oversampling UART receiver. Recovers 8N1 bytes from the
//             asynchronous host line and offers them on a valid/ready byte
//             interface. Framing errors and overruns are one-cycle pulses.
//             Optional feature macro: UART_RX_PARITY_EN (8E1 framing with
//             an even-parity check; parity_err tied low when undefined).
//  Ports    : clk        - system clock
//             rst        - synchronous active-high reset
//             rxd        - asynchronous serial line, idle high
//             data       - received byte, LSB = first data bit
//             valid      - data holds an unconsumed byte
//             ready      - consumer accepts data when valid && ready
//             frame_err  - pulse: stop bit sampled low
//             overrun    - pulse: completed byte dropped, holding reg full
//             parity_err - pulse: parity mismatch (feature build only)
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLK_FREQ_HZ = 24180000,
    parameter int BAUD        = 115200,
    parameter int DIV         = (CLK_FREQ_HZ + 8 * BAUD) / (16 * BAUD)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int             c_cnt_w     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_tick_last = c_cnt_w'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser (reset to the idle-line level)
    // ------------------------------------------------------------------
    logic sync1_q, sync2_q;
    logic w_rxs;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
        end
    end

    assign w_rxs = sync2_q;

    // ------------------------------------------------------------------
    // Receive state machine
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [3:0]         os_q, os_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               deliver_q, deliver_d;
    logic               ferr_d;
    logic               w_tick;
`ifdef UART_RX_PARITY_EN
    logic               pbad_q, pbad_d;
`endif

    assign w_tick = (cnt_q == c_tick_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            os_q      <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            deliver_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbad_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            os_q      <= os_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            deliver_q <= deliver_d;
`ifdef UART_RX_PARITY_EN
            pbad_q    <= pbad_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = w_tick ? '0 : cnt_q + c_cnt_w'(1);
        os_d      = os_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        deliver_d = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        pbad_d    = pbad_q;
`endif

        case (state_q)
            S_IDLE: begin
                // Restart the tick phase on the edge so the start-bit
                // midpoint lands exactly 8 ticks later.
                if (!w_rxs) begin
                    state_d = S_START;
                    os_d    = '0;
                    cnt_d   = '0;
                end
            end

            S_START: begin
                if (w_tick) begin
                    if (os_q == 4'd7) begin
                        if (!w_rxs) begin
                            state_d = S_DATA;
                            os_d    = '0;
                            idx_d   = '0;
                        end else begin
                            state_d = S_IDLE;   // glitch, not a real start
                        end
                    end else begin
                        os_d = os_q + 4'd1;
                    end
                end
            end

            S_DATA: begin
                if (w_tick) begin
                    os_d = os_q + 4'd1;
                    if (os_q == 4'd15) begin
                        // Shift in from the top: after 8 bits the first
                        // received bit sits in bit 0.
                        shift_d = {w_rxs, shift_q[7:1]};
                        if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    os_d = os_q + 4'd1;
                    if (os_q == 4'd15) begin
                        pbad_d  = (w_rxs != (^shift_q));
                        state_d = S_STOP;
                    end
                end
            end
`endif

            S_STOP: begin
                if (w_tick) begin
                    os_d = os_q + 4'd1;
                    if (os_q == 4'd15) begin
                        if (w_rxs) begin
                            state_d   = S_IDLE;
                            deliver_d = 1'b1;
                        end else begin
                            state_d = S_BREAK;
                            ferr_d  = 1'b1;
                        end
                    end
                end
            end

            S_BREAK: begin
                if (w_rxs) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Holding register and status pulses
    // ------------------------------------------------------------------
    logic [7:0] data_q;
    logic       valid_q;
    logic       frame_err_q;
    logic       overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= ferr_d;
            overrun_q   <= 1'b0;

            if (valid_q && ready) begin
                valid_q <= 1'b0;
            end

            if (deliver_q) begin
`ifdef UART_RX_PARITY_EN
                if (!pbad_q) begin
`endif
                    // A same-cycle consume frees the slot for the new byte.
                    if (!valid_q || ready) begin
                        data_q  <= shift_q;
                        valid_q <= 1'b1;
                    end else begin
                        overrun_q <= 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                end
`endif
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else begin
            // Only reachable after a good stop bit, so a framing error
            // always wins over a parity error for the same byte.
            parity_err_q <= deliver_q && pbad_q;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx at 16 clk per bit. Expected
//             bytes go to a scoreboard queue when a frame is driven and are
//             popped on each valid/ready handshake; pulse outputs are counted.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CLK_FREQ_HZ = 1600000;
    localparam int BAUD        = 100000;
    localparam int BIT_CLKS    = 16;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       rxd   = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .BAUD        (BAUD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic       par_flip;
        logic       exp_del;
        int         exp_ferr;
        int         exp_perr;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_ferr  = 0;
    int         n_ovr   = 0;
    int         n_perr  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_bit(input logic v);
        rxd = v;
        repeat (BIT_CLKS) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input logic pflip);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        hold_bit((^b) ^ pflip);
`else
        if (pflip) $display("note: parity flip ignored in 8N1 build");
`endif
        hold_bit(stop);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    function automatic vec_t mk(input logic [7:0] d, input logic s, input logic pf,
                                input logic del, input int fe, input int pe);
        vec_t v;
        v.data = d; v.stop_ok = s; v.par_flip = pf;
        v.exp_del = del; v.exp_ferr = fe; v.exp_perr = pe;
        return v;
    endfunction

    task automatic monitor();
        logic       pv, pacc;
        logic [7:0] pd, e;
        pv = 1'b0; pacc = 1'b0; pd = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
                pacc = 1'b0;
            end else begin
                n_ferr += int'(frame_err);
                n_ovr  += int'(overrun);
                n_perr += int'(parity_err);
                if (pv && !pacc && valid) check("data stable while valid", {24'h0, data}, {24'h0, pd});
                if (valid && ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected byte: got 0x%0h, expected none", data);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx data", {24'h0, data}, {24'h0, e});
                    end
                end
                pv   = valid;
                pacc = valid && ready;
                pd   = data;
            end
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1);
    end

    initial begin
        int f0, o0, p0;

        vecs.push_back(mk(8'hA5, 1'b1, 1'b0, 1'b1, 0, 0));
        vecs.push_back(mk(8'h3C, 1'b1, 1'b0, 1'b1, 0, 0));
        vecs.push_back(mk(8'h55, 1'b0, 1'b0, 1'b0, 1, 0));
        vecs.push_back(mk(8'h80, 1'b1, 1'b0, 1'b1, 0, 0));
        vecs.push_back(mk(8'h01, 1'b1, 1'b0, 1'b1, 0, 0));
`ifdef UART_RX_PARITY_EN
        vecs.push_back(mk(8'h03, 1'b1, 1'b0, 1'b1, 0, 0));
        vecs.push_back(mk(8'h03, 1'b1, 1'b1, 1'b0, 0, 1));
        vecs.push_back(mk(8'h03, 1'b0, 1'b1, 1'b0, 1, 0));
`endif

        fork
            monitor();
        join_none

        // Reset with the line low, release to idle
        rst = 1'b1;
        rxd = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        rxd = 1'b1;
        check("reset data", {24'h0, data}, 32'h0);
        check("reset valid", {31'h0, valid}, 32'h0);
        check("reset frame_err", {31'h0, frame_err}, 32'h0);
        check("reset overrun", {31'h0, overrun}, 32'h0);
        check("reset parity_err", {31'h0, parity_err}, 32'h0);
        repeat (200) tick();
        check("no byte after reset", {31'h0, valid}, 32'h0);
        check("no frame_err after reset", n_ferr, 0);

        // Table-driven frames with ready held high
        ready = 1'b1;
        foreach (vecs[i]) begin
            f0 = n_ferr; o0 = n_ovr; p0 = n_perr;
            if (vecs[i].exp_del) exp_q.push_back(vecs[i].data);
            send_byte(vecs[i].data, vecs[i].stop_ok, vecs[i].par_flip);
            rxd = 1'b1;
            repeat (32) tick();
            wait_drain($sformatf("vec%0d drained", i));
            check($sformatf("vec%0d frame_err count", i), n_ferr - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d parity_err count", i), n_perr - p0, vecs[i].exp_perr);
            check($sformatf("vec%0d overrun count", i), n_ovr - o0, 0);
            check($sformatf("vec%0d valid idle", i), {31'h0, valid}, 32'h0);
        end

        // Backpressure: second byte overruns, first is held
        ready = 1'b0;
        f0 = n_ferr; o0 = n_ovr;
        exp_q.push_back(8'h12);
        send_byte(8'h12, 1'b1, 1'b0);
        rxd = 1'b1;
        repeat (8) tick();
        send_byte(8'h34, 1'b1, 1'b0);
        rxd = 1'b1;
        repeat (32) tick();
        check("overrun pulse count", n_ovr - o0, 1);
        check("held valid", {31'h0, valid}, 32'h1);
        check("held data", {24'h0, data}, 32'h12);
        check("overrun no frame_err", n_ferr - f0, 0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("held byte consumed", exp_q.size(), 0);
        check("valid cleared after accept", {31'h0, valid}, 32'h0);
        ready = 1'b1;

        // Framing error followed by a long break, then a good byte
        f0 = n_ferr;
        send_byte(8'h55, 1'b0, 1'b0);
        rxd = 1'b0;
        repeat (40 * BIT_CLKS) tick();
        rxd = 1'b1;
        repeat (64) tick();
        check("break frame_err count", n_ferr - f0, 1);
        check("break nothing delivered", {31'h0, valid}, 32'h0);
        exp_q.push_back(8'h0F);
        send_byte(8'h0F, 1'b1, 1'b0);
        rxd = 1'b1;
        repeat (32) tick();
        wait_drain("after-break byte drained");
        check("after-break frame_err count", n_ferr - f0, 1);

        // Short glitch must be rejected
        f0 = n_ferr;
        rxd = 1'b0;
        repeat (4) tick();
        rxd = 1'b1;
        repeat (64) tick();
        check("glitch no byte", {31'h0, valid}, 32'h0);
        check("glitch no frame_err", n_ferr - f0, 0);

        // Back-to-back frames with no idle bits
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0);
        rxd = 1'b1;
        repeat (32) tick();
        wait_drain("back-to-back drained");
        check("back-to-back no frame_err", n_ferr - f0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
